// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack fetches to a variable-latency
// instruction memory and presents instructions to decode through a one-entry skid buffer.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instruction;
    logic        transfer;
    logic        accept;
    logic        consume;

    // The PC only moves once a fetch completes, so in DRAIN it still names the old request.
    assign imem_addr = pc;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_next = state;
        imem_req   = 1'b0;
        unique case (state)
            IDLE:        imem_req = !skid_valid && !redirect_valid;
            WAIT, DRAIN: imem_req = 1'b1;
            default:     imem_req = 1'b0;
        endcase
        if (reset) begin
            imem_req = 1'b0;
        end

        transfer = imem_req && imem_ack;
        accept   = transfer && (state != DRAIN) && !redirect_valid;
        consume  = if_valid && !stall;

        unique case (state)
            IDLE:    if (imem_req && !imem_ack) state_next = WAIT;
            WAIT: begin
                if (transfer)            state_next = IDLE;
                else if (redirect_valid) state_next = DRAIN;
            end
            DRAIN:   if (transfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            pending_pc <= 32'h0;
        end else if (redirect_valid) begin
            // Without an outstanding request (or once it completes) retarget now; else park it.
            if (state == IDLE || transfer) begin
                pc <= redirect_pc;
            end else begin
                pending_pc <= redirect_pc;
            end
        end else if (transfer) begin
            pc <= (state == DRAIN) ? pending_pc : pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid         <= 1'b0;
            if_pc            <= 32'h0;
            if_instruction   <= 32'h0;
            skid_valid       <= 1'b0;
            skid_pc          <= 32'h0;
            skid_instruction <= 32'h0;
        end else if (redirect_valid) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                if_pc          <= skid_pc;
                if_instruction <= skid_instruction;
                skid_valid     <= 1'b0;
            end else if (accept) begin
                if_pc          <= pc;
                if_instruction <= imem_rdata;
            end else begin
                if_valid <= 1'b0;
            end
        end else if (accept) begin
            // Output empty takes the beat directly; a stalled full output pushes it to the skid.
            if (!if_valid) begin
                if_pc          <= pc;
                if_instruction <= imem_rdata;
                if_valid       <= 1'b1;
            end else begin
                skid_pc          <= pc;
                skid_instruction <= imem_rdata;
                skid_valid       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: programmable-latency memory responder, an in-order
// presentation model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    logic        force_ack = 1'b0;
    int          latency = 0;
    int          lat_cnt;
    int          n_checks = 0;
    int          n_pass = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: acks after the request has been held for `latency` cycles.
    always @(posedge clk or posedge reset) begin
        if (reset || !imem_req || imem_ack) lat_cnt <= 0;
        else                                lat_cnt <= lat_cnt + 1;
    end

    assign imem_ack   = force_ack || (imem_req && (lat_cnt >= latency));
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: decode must see consecutive PCs from RESET_PC, restarting at each redirect target.
    logic [31:0] exp_pc = 32'h0;
    logic        prev_redirect = 1'b0;
    logic        prev_hold = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_pc, prev_instr, prev_addr;

    always begin
        @(negedge clk);
        if (reset) begin
            check("model reset req", {31'b0, imem_req}, 32'd0);
            check("model reset if_valid", {31'b0, if_valid}, 32'd0);
            exp_pc        = 32'h0;
            prev_redirect = 1'b0;
            prev_hold     = 1'b0;
            prev_wait     = 1'b0;
        end else begin
            if (prev_redirect) begin
                check("model flush if_valid", {31'b0, if_valid}, 32'd0);
            end else if (prev_hold) begin
                check("model hold if_valid", {31'b0, if_valid}, 32'd1);
                check("model hold if_pc", if_pc, prev_pc);
                check("model hold if_instruction", if_instruction, prev_instr);
            end
            if (prev_wait) begin
                check("model held req", {31'b0, imem_req}, 32'd1);
                check("model held addr", imem_addr, prev_addr);
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end else if (if_valid && !stall) begin
                check("model order if_pc", if_pc, exp_pc);
                check("model order if_instruction", if_instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            prev_redirect = redirect_valid;
            prev_hold     = if_valid && stall && !redirect_valid;
            prev_wait     = imem_req && !imem_ack;
            prev_pc       = if_pc;
            prev_instr    = if_instruction;
            prev_addr     = imem_addr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the caller just after the edge that opens the first post-reset cycle.
    task automatic start(input int lat);
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        force_ack      = 1'b0;
        latency        = lat;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    int n_valid;

    initial begin
        // Zero-wait memory: one fetch per cycle, first beat presented in cycle 2.
        start(0);
        smp();
        check("t1 c1 req", {31'b0, imem_req}, 32'd1);
        check("t1 c1 addr", imem_addr, 32'h0);
        check("t1 c1 if_valid", {31'b0, if_valid}, 32'd0);
        cyc(); smp();
        check("t1 c2 addr", imem_addr, 32'h4);
        check("t1 c2 if_valid", {31'b0, if_valid}, 32'd1);
        check("t1 c2 if_pc", if_pc, 32'h0);
        check("t1 c2 if_instruction", if_instruction, 32'hA5A5_FFFF);
        cyc(); smp();
        check("t1 c3 addr", imem_addr, 32'h8);
        check("t1 c3 if_pc", if_pc, 32'h4);

        // Three-cycle latency: request held on 0x0 for three cycles, acked in the fourth.
        start(3);
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) cyc();
            smp();
            check("t2 wait req", {31'b0, imem_req}, 32'd1);
            check("t2 wait addr", imem_addr, 32'h0);
            check("t2 wait ack", {31'b0, imem_ack}, 32'd0);
        end
        cyc(); smp();
        check("t2 c4 ack", {31'b0, imem_ack}, 32'd1);
        cyc(); smp();
        check("t2 c5 if_valid", {31'b0, if_valid}, 32'd1);
        check("t2 c5 if_pc", if_pc, 32'h0);
        check("t2 c5 addr", imem_addr, 32'h4);
        cyc(); smp();
        check("t2 c6 if_valid", {31'b0, if_valid}, 32'd0);
        n_valid = 0;
        for (int i = 7; i <= 13; i++) begin
            cyc(); smp();
            if (if_valid) n_valid++;
        end
        check("t2 valid beats c7..c13", n_valid, 32'd2);
        check("t2 c13 if_pc", if_pc, 32'h8);

        // Stall while 0x8 is presented: 0xC parks in the skid, no request until release.
        start(0);
        cyc(); cyc();
        cyc(); stall = 1'b1; smp();
        check("t3 c4 if_pc", if_pc, 32'h8);
        check("t3 c4 ack addr", imem_addr, 32'hC);
        check("t3 c4 ack", {31'b0, imem_ack}, 32'd1);
        for (int i = 5; i <= 6; i++) begin
            cyc(); smp();
            check("t3 stalled req", {31'b0, imem_req}, 32'd0);
            check("t3 stalled if_pc", if_pc, 32'h8);
        end
        cyc(); stall = 1'b0; smp();
        check("t3 c7 if_pc", if_pc, 32'h8);
        check("t3 c7 req", {31'b0, imem_req}, 32'd0);
        cyc(); smp();
        check("t3 c8 if_pc", if_pc, 32'hC);
        check("t3 c8 addr", imem_addr, 32'h10);
        cyc(); smp();
        check("t3 c9 if_pc", if_pc, 32'h10);
        check("t3 c9 if_valid", {31'b0, if_valid}, 32'd1);

        // Redirect during WAIT on 0x10, ack two cycles later: drained, then refetch at 0x100.
        start(0);
        repeat (3) cyc();
        cyc(); latency = 3; smp();
        check("t4 c5 addr", imem_addr, 32'h10);
        check("t4 c5 ack", {31'b0, imem_ack}, 32'd0);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100; smp();
        check("t4 c6 addr", imem_addr, 32'h10);
        cyc(); redirect_valid = 1'b0; smp();
        check("t4 c7 req", {31'b0, imem_req}, 32'd1);
        check("t4 c7 addr", imem_addr, 32'h10);
        check("t4 c7 if_valid", {31'b0, if_valid}, 32'd0);
        cyc(); smp();
        check("t4 c8 ack", {31'b0, imem_ack}, 32'd1);
        check("t4 c8 if_valid", {31'b0, if_valid}, 32'd0);
        cyc(); latency = 0; smp();
        check("t4 c9 addr", imem_addr, 32'h100);
        check("t4 c9 if_valid", {31'b0, if_valid}, 32'd0);
        cyc(); smp();
        check("t4 c10 if_valid", {31'b0, if_valid}, 32'd1);
        check("t4 c10 if_pc", if_pc, 32'h100);

        // Redirect coinciding with an ack in WAIT while decode is stalled.
        start(0);
        cyc(); cyc();
        cyc(); stall = 1'b1; latency = 1; smp();
        check("t5a c4 addr", imem_addr, 32'hC);
        check("t5a c4 ack", {31'b0, imem_ack}, 32'd0);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200; smp();
        check("t5a c5 ack", {31'b0, imem_ack}, 32'd1);
        cyc(); redirect_valid = 1'b0; stall = 1'b0; latency = 0; smp();
        check("t5a c6 if_valid", {31'b0, if_valid}, 32'd0);
        check("t5a c6 addr", imem_addr, 32'h200);
        cyc(); smp();
        check("t5a c7 if_pc", if_pc, 32'h200);

        // Redirect with skid full and stall high, stray ack ignored; then PC wrap at 2^32.
        start(0);
        cyc(); cyc();
        cyc(); stall = 1'b1; smp();
        check("t5b c4 ack", {31'b0, imem_ack}, 32'd1);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200; force_ack = 1'b1; smp();
        check("t5b c5 req", {31'b0, imem_req}, 32'd0);
        check("t5b c5 if_pc", if_pc, 32'h8);
        cyc(); redirect_valid = 1'b0; stall = 1'b0; force_ack = 1'b0; smp();
        check("t5b c6 if_valid", {31'b0, if_valid}, 32'd0);
        check("t5b c6 addr", imem_addr, 32'h200);
        cyc(); smp();
        check("t5b c7 if_pc", if_pc, 32'h200);
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; smp();
        check("t5b c8 if_pc", if_pc, 32'h204);
        check("t5b c8 req", {31'b0, imem_req}, 32'd0);
        cyc(); redirect_valid = 1'b0; smp();
        check("t5b c9 addr", imem_addr, 32'hFFFF_FFF8);
        cyc(); smp();
        check("t5b c10 if_pc", if_pc, 32'hFFFF_FFF8);
        check("t5b c10 addr", imem_addr, 32'hFFFF_FFFC);
        cyc(); smp();
        check("t5b c11 addr wrap", imem_addr, 32'h0);
        cyc(); smp();
        check("t5b c12 if_pc wrap", if_pc, 32'h0);

        // Reset asserted mid-WAIT on 0x40, with a late ack while reset is high.
        start(0);
        repeat (15) cyc();
        cyc(); latency = 5; smp();
        check("t6 c17 addr", imem_addr, 32'h40);
        check("t6 c17 ack", {31'b0, imem_ack}, 32'd0);
        cyc(); reset = 1'b1; force_ack = 1'b1; smp();
        check("t6 c18 req", {31'b0, imem_req}, 32'd0);
        check("t6 c18 if_valid", {31'b0, if_valid}, 32'd0);
        cyc();
        cyc(); reset = 1'b0; force_ack = 1'b0; latency = 0; smp();
        check("t6 c20 req", {31'b0, imem_req}, 32'd1);
        check("t6 c20 addr", imem_addr, 32'h0);
        cyc(); smp();
        check("t6 c21 if_pc", if_pc, 32'h0);
        check("t6 c21 if_valid", {31'b0, if_valid}, 32'd1);

        cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls instruction fetch for the pipelined core. It replaces the free-running PC+4 fetch with a sequenced one: it owns the PC and drives a request/acknowledge handshake to a variable-latency instruction memory. It presents fetched instructions to decode under a valid/stall handshake, and handles branch/jump redirects, including discarding a request already in flight. It sits between the instruction-memory port and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
PC_STEP, 4, byte increment between sequential fetches.

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  instruction memory request.
imem_addr  output  32  request address; stable while imem_req=1 and no ack.
imem_ack  input  1  memory acknowledge; may assert in the same cycle as imem_req (zero-wait).
imem_rdata  input  32  instruction; valid only in an imem_ack cycle.
redirect_valid  input  1  one-cycle pulse: branch/jump taken, flush and refetch.
redirect_pc  input  32  redirect target; sampled when redirect_valid=1.
stall  input  1  decode cannot accept; holds if_* outputs.
if_valid  output  1  if_pc/if_instruction hold a valid instruction.
if_pc  output  32  PC of the presented instruction.
if_instruction  output  32  presented instruction.

Behaviour:
- Reset (asynchronous, active-high):
  - pc=RESET_PC, state=IDLE, if_valid=0, skid_valid=0.
  - if_pc=0, if_instruction=0, pending_pc=0.
  - imem_req=0 while reset is high.
- States:
  - IDLE: no request outstanding.
  - WAIT: request issued, not yet acked.
  - DRAIN: request outstanding whose result must be discarded.
- Issue:
  - In IDLE, imem_req=1 when skid_valid=0 and redirect_valid=0.
  - imem_req=1 unconditionally in WAIT and DRAIN.
  - imem_addr=pc in IDLE and WAIT. In DRAIN it is the old address, because pc is not updated until the drain completes.
- Handshake:
  - A transfer occurs in any cycle with imem_req=1 and imem_ack=1.
  - Once imem_req is raised, it is held with an unchanged address until ack, regardless of stall or redirect.
  - imem_ack while imem_req=0 is ignored.
- Transitions:
  - IDLE, request issued, ack in the same cycle: accept the data, pc+=PC_STEP, stay IDLE.
  - IDLE, request issued, no ack: go to WAIT.
  - WAIT, ack: accept the data, pc+=PC_STEP, go to IDLE.
  - DRAIN, ack: discard the data, pc<=pending_pc, go to IDLE.
- Accepted data (pc of the request, rdata):
  - If if_valid=0 or stall=0 that cycle, load it into the output register; if_valid=1 next cycle.
  - Otherwise load it into the one-entry skid register; skid_valid=1.
- Output consumption:
  - A beat is consumed when if_valid=1 and stall=0.
  - On consumption, the skid (if valid) moves to the output register. Otherwise the output takes the same-cycle accepted data, or if_valid goes to 0.
  - While stall=1, if_* are held.
- Redirect (priority over stall and over accepting data):
  - The next cycle has if_valid=0 and skid_valid=0.
  - IDLE, no request: pc<=redirect_pc; no request that cycle.
  - Ack in the same cycle (IDLE or WAIT): discard the data, pc<=redirect_pc, go to IDLE.
  - WAIT without ack: pending_pc<=redirect_pc, go to DRAIN.
  - DRAIN: pending_pc<=redirect_pc (latest wins). If ack arrives the same cycle, pc<=redirect_pc and go to IDLE.
- Arithmetic: the PC adds modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. No alignment checking.
- Throughput and latency:
  - Zero-wait memory, no stall: one instruction per cycle.
  - First request is issued in the first cycle after reset deasserts. That instruction appears on if_* the cycle after its ack.
- Ordering: instructions are presented in fetch order, never duplicated or dropped except by redirect.

Test Plan:
- Reset then zero-wait memory (ack=req), stall=0 -> imem_addr 0,4,8,... on consecutive cycles; if_pc 0,4,8 with if_valid=1 from the 2nd post-reset cycle; if_instruction equals the memory word.
- Memory with 3-cycle ack latency -> imem_addr stays 0x0 and imem_req stays 1 for 3 cycles; if_valid=1 for exactly one cycle per fetch; if_pc sequence 0,4,8.
- Zero-wait memory, stall high for 3 cycles while if_pc=0x8 -> if_* hold 0x8; the skid captures 0xC; no new request until release; then 0xC, 0x10 in order with no gap or duplicate.
- Redirect to 0x100 during WAIT at addr 0x10, ack two cycles later -> DRAIN; the 0x10 data is never presented; next imem_addr=0x100; if_valid=0 until the 0x100 instruction appears.
- Redirect in the same cycle as ack, target 0x200, with stall=1 and skid full -> output and skid flushed; next request to 0x200; the acked data is discarded.
- Assert reset mid-WAIT, PC=0x40 -> imem_req=0 and if_valid=0 immediately; after release, the first request is to RESET_PC; a late ack arriving while reset is high is ignored.
